// File: rtl/tri_depth_writer.sv
// rtl/tri_depth_writer.sv - bbox scan, z-buffer depth test and frame-buffer write for one triangle
module tri_depth_writer #(
    parameter int               H_RES  = 640,
    parameter int               V_RES  = 480,
    parameter int               ADDR_W = 19,
    parameter logic signed [19:0] Z_FAR = 20'sh7FFFF
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic                     clear_start,
    input  logic [2:0][35:0]         proj_vertex_in,
    output logic [10:0]              x,
    output logic [10:0]              y,
    input  logic signed [19:0]       z_in,
    input  logic [23:0]              color_in,
    output logic [ADDR_W-1:0]        zb_addr,
    output logic                     zb_rd_en,
    input  logic signed [19:0]       zb_rdata,
    output logic                     zb_wr_en,
    output logic [19:0]              zb_wdata,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic                     fb_wr_en,
    output logic [23:0]              fb_wdata,
    input  logic                     fb_ready,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        pix_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETUP, S_RD, S_CMP, S_WR, S_NEXT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [10:0] X_LIM = 11'(H_RES);
    localparam logic [10:0] Y_LIM = 11'(V_RES);
    localparam logic [10:0] X_TOP = 11'(H_RES - 1);
    localparam logic [10:0] Y_TOP = 11'(V_RES - 1);

    state_t                   state, state_nxt;
    logic [2:0][9:0]          vx, vy;
    logic [10:0]              xmin, xmax, ymax;
    logic [10:0]              bx_min, bx_max, by_min, by_max;
    logic                     reject;
    logic signed [19:0]       z_lat;
    logic [23:0]              color_lat;
    logic [ADDR_W-1:0]        clr_addr;
    logic [ADDR_W-1:0]        pix_addr;
    logic                     cmp_pass;
    logic                     last_col, last_row;
    logic                     unused_vz;

    assign unused_vz = ^{proj_vertex_in[2][15:0], proj_vertex_in[1][15:0], proj_vertex_in[0][15:0]};

    assign pix_addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    assign cmp_pass = (z_in != 20'sh80000) && (z_in < zb_rdata);
    assign last_col = (x == xmax);
    assign last_row = (y == ymax);

    // Starting min at the screen edge also clamps a vertex sitting exactly on H_RES/V_RES.
    always_comb begin
        reject = 1'b0;
        bx_min = X_TOP;
        bx_max = '0;
        by_min = Y_TOP;
        by_max = '0;
        for (int i = 0; i < 3; i++) begin
            if (11'(vx[i]) > X_LIM || 11'(vy[i]) > Y_LIM) reject = 1'b1;
            if (11'(vx[i]) < bx_min) bx_min = 11'(vx[i]);
            if (11'(vx[i]) > bx_max) bx_max = 11'(vx[i]);
            if (11'(vy[i]) < by_min) by_min = 11'(vy[i]);
            if (11'(vy[i]) > by_max) by_max = 11'(vy[i]);
        end
        if (bx_max > X_TOP) bx_max = X_TOP;
        if (by_max > Y_TOP) by_max = Y_TOP;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clear_start) state_nxt = S_CLEAR;
                     else if (start)  state_nxt = S_SETUP;
            S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_DONE;
            S_SETUP: state_nxt = reject ? S_DONE : S_RD;
            S_RD:    state_nxt = S_CMP;
            S_CMP:   state_nxt = cmp_pass ? S_WR : S_NEXT;
            S_WR:    if (fb_ready) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = (last_col && last_row) ? S_DONE : S_RD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        zb_rd_en = (state == S_RD);
        fb_wr_en = (state == S_WR);
        zb_wr_en = (state == S_CLEAR) || ((state == S_WR) && fb_ready);
        zb_addr  = (state == S_CLEAR) ? clr_addr : pix_addr;
        zb_wdata = '0;
        if (state == S_CLEAR)   zb_wdata = Z_FAR;
        else if (state == S_WR) zb_wdata = z_lat;
        fb_addr  = pix_addr;
        fb_wdata = color_lat;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vx        <= '0;
            vy        <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
            x         <= '0;
            y         <= '0;
            z_lat     <= '0;
            color_lat <= '0;
            clr_addr  <= '0;
            pix_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    clr_addr <= '0;
                    if (start && !clear_start) begin
                        for (int i = 0; i < 3; i++) begin
                            vx[i] <= proj_vertex_in[i][35:26];
                            vy[i] <= proj_vertex_in[i][25:16];
                        end
                        pix_count <= '0;
                    end
                end
                S_CLEAR: clr_addr <= clr_addr + 1'b1;
                S_SETUP: if (!reject) begin
                    xmin <= bx_min;
                    xmax <= bx_max;
                    ymax <= by_max;
                    x    <= bx_min;
                    y    <= by_min;
                end
                S_CMP: begin
                    z_lat     <= z_in;
                    color_lat <= color_in;
                end
                S_WR: if (fb_ready) pix_count <= pix_count + 1'b1;
                S_NEXT: begin
                    // The final pixel leaves x/y untouched so they hold through DONE.
                    if (!last_col) begin
                        x <= x + 1'b1;
                    end else if (!last_row) begin
                        x <= xmin;
                        y <= y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_depth_writer.sv
// tb/tb_tri_depth_writer.sv - directed bench for tri_depth_writer on a 64x48 screen
module tb_tri_depth_writer;

    localparam int HR = 64;
    localparam int VR = 48;
    localparam int NP = HR * VR;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               start, clear_start, fb_ready;
    logic [2:0][35:0]   proj_vertex_in;
    logic [10:0]        x, y;
    logic signed [19:0] z_in;
    logic [23:0]        color_in;
    logic [18:0]        zb_addr, fb_addr, pix_count;
    logic               zb_rd_en, zb_wr_en, fb_wr_en, busy, done;
    logic signed [19:0] zb_rdata;
    logic [19:0]        zb_wdata;
    logic [23:0]        fb_wdata;
    logic signed [19:0] zval;
    logic [19:0]        zmem [0:NP-1];

    int n_total = 0, n_pass = 0;
    int cyc = 0, n_rd = 0, n_fbw = 0, n_zbw = 0, n_busy = 0, n_bad = 0;

    tri_depth_writer #(.H_RES(HR), .V_RES(VR), .ADDR_W(19)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .clear_start(clear_start),
        .proj_vertex_in(proj_vertex_in), .x(x), .y(y), .z_in(z_in), .color_in(color_in),
        .zb_addr(zb_addr), .zb_rd_en(zb_rd_en), .zb_rdata(zb_rdata), .zb_wr_en(zb_wr_en),
        .zb_wdata(zb_wdata), .fb_addr(fb_addr), .fb_wr_en(fb_wr_en), .fb_wdata(fb_wdata),
        .fb_ready(fb_ready), .busy(busy), .done(done), .pix_count(pix_count)
    );

    always #5 Clk = ~Clk;

    function automatic bit in_tri(input int px, input int py);
        return px >= 10 && py >= 10 && (px - 10) + (py - 10) <= 10;
    endfunction

    function automatic logic [23:0] col(input int px, input int py);
        return {8'(px), 8'(py), 8'h5A};
    endfunction

    function automatic logic [35:0] pv(input int vx, input int vy);
        return {10'(vx), 10'(vy), 16'h0000};
    endfunction

    // Interpolator stub: constant depth inside one fixed triangle, outside marker elsewhere.
    always_comb begin
        z_in     = in_tri(int'(x), int'(y)) ? zval : 20'sh80000;
        color_in = col(int'(x), int'(y));
    end

    always @(posedge Clk) begin
        if (zb_wr_en && int'(zb_addr) < NP) zmem[zb_addr] <= zb_wdata;
        if (zb_rd_en && int'(zb_addr) < NP) zb_rdata <= zmem[zb_addr];
    end

    always @(negedge Clk) begin : monitor
        int ax, ay;
        cyc <= cyc + 1;
        if (zb_rd_en) n_rd <= n_rd + 1;
        if (zb_wr_en) n_zbw <= n_zbw + 1;
        if (busy) n_busy <= n_busy + 1;
        if (fb_wr_en && fb_ready) begin
            n_fbw <= n_fbw + 1;
            ax = int'(fb_addr) % HR;
            ay = int'(fb_addr) / HR;
            if (!in_tri(ax, ay) || fb_wdata != col(ax, ay) || zb_wdata != zval || !zb_wr_en)
                n_bad <= n_bad + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int zv;
        int reads, writes, first;
    } vec_t;

    int first_rd;

    task automatic pulse_start();
        @(posedge Clk); #1 start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge Clk);
            if (zb_rd_en && first_rd < 0) first_rd = int'(zb_addr);
            k++;
        end
        chk({name, "_done_seen"}, done, 1);
        @(posedge Clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rd0, fb0, zb0, bs0, bad0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        zval = 20'(v.zv);
        proj_vertex_in = {pv(v.x2, v.y2), pv(v.x1, v.y1), pv(v.x0, v.y0)};
        first_rd = -1;
        rd0 = n_rd; fb0 = n_fbw; zb0 = n_zbw; bs0 = n_busy; bad0 = n_bad;
        pulse_start();
        wait_done(nm);
        chk({nm, "_reads"}, n_rd - rd0, v.reads);
        chk({nm, "_fb_writes"}, n_fbw - fb0, v.writes);
        chk({nm, "_zb_writes"}, n_zbw - zb0, v.writes);
        chk({nm, "_pix_count"}, pix_count, v.writes);
        chk({nm, "_busy_cycles"}, n_busy - bs0, 2 + 3 * v.reads + v.writes);
        chk({nm, "_bad_writes"}, n_bad - bad0, 0);
        chk({nm, "_first_addr"}, first_rd, v.first);
    endtask

    vec_t vecs [11];

    initial begin
        int exp_a, clr_bad, last_w, done_at, k, stall_bad;
        logic [18:0] a_hold;
        logic [23:0] d_hold;

        vecs[0]  = '{10, 10, 20, 10, 10, 20, 100, 121, 66, 650};
        vecs[1]  = '{10, 10, 20, 10, 10, 20, 200, 121, 0, 650};
        vecs[2]  = '{10, 10, 20, 10, 10, 20, 50, 121, 66, 650};
        vecs[3]  = '{10, 10, 20, 10, 10, 20, 50, 121, 0, 650};
        vecs[4]  = '{700, 10, 20, 10, 10, 20, 10, 0, 0, -1};
        vecs[5]  = '{30, 5, 30, 5, 30, 5, 10, 1, 0, 350};
        vecs[6]  = '{12, 12, 12, 12, 12, 12, 40, 1, 1, 780};
        vecs[7]  = '{10, 15, 20, 15, 15, 15, 40, 11, 6, 970};
        vecs[8]  = '{60, 45, 64, 48, 60, 48, 10, 12, 0, 2940};
        vecs[9]  = '{0, 0, 1, 1, 1, 49, 10, 0, 0, -1};
        vecs[10] = '{20, 10, 10, 20, 10, 10, 45, 121, 59, 650};

        Reset_n = 1'b0; start = 1'b0; clear_start = 1'b0; fb_ready = 1'b1;
        zval = '0; proj_vertex_in = '0;
        #23;
        chk("reset_outputs", |{x, y, zb_addr, zb_rd_en, zb_wr_en, zb_wdata, fb_addr,
                               fb_wr_en, fb_wdata, busy, done, pix_count}, 0);
        @(posedge Clk); #1 Reset_n = 1'b1;

        // Clear: one write per cycle over the whole screen, done right after the last.
        @(posedge Clk); #1 clear_start = 1'b1;
        @(posedge Clk); #1 clear_start = 1'b0;
        exp_a = 0; clr_bad = 0; last_w = -1; done_at = -1;
        for (int c = 0; c < NP + 100; c++) begin
            @(negedge Clk);
            if (zb_wr_en) begin
                if (int'(zb_addr) != exp_a || zb_wdata != 20'h7FFFF) clr_bad++;
                exp_a++;
                last_w = c;
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        chk("clear_count", exp_a, NP);
        chk("clear_seq_errors", clr_bad, 0);
        chk("clear_done_gap", done_at - last_w, 1);
        @(posedge Clk); #1;
        chk("clear_zmem_last", zmem[NP-1], 20'h7FFFF);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Frame buffer stalls on the first written pixel.
        zval = 20'sd10;
        proj_vertex_in = {pv(10, 20), pv(20, 10), pv(10, 10)};
        fb_ready = 1'b0;
        pulse_start();
        k = 0;
        while (!fb_wr_en && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("stall_wr_seen", fb_wr_en, 1);
        chk("stall_addr", fb_addr, 10 * HR + 10);
        a_hold = fb_addr; d_hold = fb_wdata; stall_bad = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge Clk);
            if (!fb_wr_en || fb_addr != a_hold || fb_wdata != d_hold || zb_wr_en) stall_bad++;
        end
        chk("stall_stable", stall_bad, 0);
        @(posedge Clk); #1 fb_ready = 1'b1;
        @(negedge Clk);
        chk("stall_accept_zb_wr", {zb_wr_en, fb_wr_en}, 2'b11);
        chk("stall_accept_zdata", zb_wdata, 10);
        first_rd = -1;
        wait_done("stall");
        chk("stall_pix_count", pix_count, 66);

        // Reset in the middle of a scan, then a fresh scan from the bbox origin.
        zval = 20'sd5;
        pulse_start();
        repeat (20) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("midscan_reset_outputs", |{x, y, zb_addr, zb_rd_en, zb_wr_en, zb_wdata, fb_addr,
                                       fb_wr_en, fb_wdata, busy, done, pix_count}, 0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        run_vec('{10, 10, 20, 10, 10, 20, 3, 121, 66, 650}, 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
